// File: rtl/divider.sv
// Sequential restoring divider: 10-bit / 5-bit unsigned, one quotient bit per clock.
// Optional macro DIVIDER_OVERFLOW_CHECK_EN saturates Q/R to 5'h1F on overflow or divide-by-zero.
module divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] Dividend,
  input  logic [4:0] Divider,
  output logic [4:0] Q,
  output logic [4:0] R,
  output logic       ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] OVFL = 2'd3;

  logic [1:0] state_reg;
  logic [5:0] a_reg;
  logic [4:0] qr_reg;
  logic [4:0] d_reg;
  logic [2:0] cnt_reg;
  logic [4:0] q_reg;
  logic [4:0] r_reg;
  logic       ready_reg;

  logic [5:0] a_shift;
  logic [6:0] trial;
  logic [5:0] a_iter;
  logic [4:0] qr_iter;
  logic       overflow;

  // One restoring step: shift, trial-subtract, keep or restore.
  assign a_shift = {a_reg[4:0], qr_reg[4]};
  assign trial   = {1'b0, a_shift} - {2'b00, d_reg};
  assign a_iter  = trial[6] ? a_shift : trial[5:0];
  assign qr_iter = {qr_reg[3:0], ~trial[6]};

`ifdef DIVIDER_OVERFLOW_CHECK_EN
  assign overflow = (Divider == 5'd0) || (Dividend[9:5] >= Divider);
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      qr_reg    <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= {1'b0, Dividend[9:5]};
            qr_reg    <= Dividend[4:0];
            d_reg     <= Divider;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            state_reg <= overflow ? OVFL : BUSY;
          end
        end
        BUSY: begin
          a_reg   <= a_iter;
          qr_reg  <= qr_iter;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd4) begin
            q_reg     <= qr_iter;
            r_reg     <= a_iter[4:0];
            ready_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        OVFL: begin
          q_reg     <= 5'h1F;
          r_reg     <= 5'h1F;
          ready_reg <= 1'b1;
          state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Q     = q_reg;
  assign R     = r_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected Q/R and accept cycle,
// a monitor pops on each rising ready and checks value and latency.
module tb_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] Dividend;
  logic [4:0] Divider;
  logic [4:0] Q;
  logic [4:0] R;
  logic       ready;

  typedef struct {
    logic [4:0] q;
    logic [4:0] r;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Dividend (Dividend),
    .Divider  (Divider),
    .Q        (Q),
    .R        (R),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Independent reference: restoring division as integer compare/subtract.
  function automatic logic [9:0] model(input logic [9:0] dvd, input logic [4:0] dvs);
    logic [5:0] a;
    logic [4:0] qr;
    a  = {1'b0, dvd[9:5]};
    qr = dvd[4:0];
    for (int i = 0; i < 5; i++) begin
      a  = {a[4:0], qr[4]};
      qr = {qr[3:0], 1'b0};
      if (int'(a) >= int'(dvs)) begin
        a     = a - 6'(dvs);
        qr[0] = 1'b1;
      end
    end
    return {qr, a[4:0]};
  endfunction

  // Monitor: pop on rising ready, check hold while ready stays high.
  initial begin
    logic       prev_ready;
    logic [4:0] held_q;
    logic [4:0] held_r;
    exp_t       e;
    prev_ready = 1'b0;
    held_q = '0;
    held_r = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_ready = 1'b0;
      end else begin
        if (ready && !prev_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_ready", 1, 0);
          end else begin
            e = sb.pop_front();
            check("Q", int'(Q), int'(e.q));
            check("R", int'(R), int'(e.r));
            check("latency", cyc - e.acc, e.lat);
            $display("result Q=%0d R=%0d at cycle %0d", Q, R, cyc);
          end
          held_q = Q;
          held_r = R;
        end else if (ready && prev_ready) begin
          check("hold_Q", int'(Q), int'(held_q));
          check("hold_R", int'(R), int'(held_r));
        end
        prev_ready = ready;
      end
    end
  end

  // Drive operands and start at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int dvd, input int dvs, input int eq, input int er, input int lat);
    exp_t e;
    Dividend = 10'(dvd);
    Divider  = 5'(dvs);
    start    = 1'b1;
    e.q = 5'(eq);
    e.r = 5'(er);
    e.acc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
    $display("issue %0d/%0d expect Q=%0d R=%0d", dvd, dvs, eq, er);
    @(negedge clk);
    check("ready_drop", int'(ready), 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  int dvd_tab[4] = '{22, 54, 150, 214};
  int dvs_tab[4] = '{3, 7, 15, 14};
  int q_tab[4]   = '{7, 7, 10, 15};
  int r_tab[4]   = '{1, 5, 0, 4};

  initial begin
    logic [9:0] m;
    int c;
    rst = 1'b0;
    start = 1'b0;
    Dividend = '0;
    Divider = '0;
    repeat (3) @(negedge clk);
    check("reset_Q", int'(Q), 0);
    check("reset_R", int'(R), 0);
    check("reset_ready", int'(ready), 0);
    rst = 1'b1;
    @(negedge clk);

    // start pulsed for two cycles; the second is during BUSY
    issue(26, 5, 5, 1, 5);
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      issue(dvd_tab[i], dvs_tab[i], q_tab[i], r_tab[i], 5);
      start = 1'b0;
      wait_ready();
    end

    // start toggles and operands change while BUSY
    issue(26, 5, 5, 1, 5);
    Dividend = 10'd1000;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Divider = 5'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    @(negedge clk);

    // asynchronous reset during the third iteration
    Dividend = 10'd150;
    Divider = 5'd15;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_Q", int'(Q), 0);
    check("abort_R", int'(R), 0);
    check("abort_ready", int'(ready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(214, 14, 15, 4, 5);
    start = 1'b0;
    wait_ready();

`ifdef DIVIDER_OVERFLOW_CHECK_EN
    issue(500, 5, 31, 31, 1);
    start = 1'b0;
    wait_ready();
    issue(100, 0, 31, 31, 1);
    start = 1'b0;
    wait_ready();
`else
    m = model(10'd500, 5'd5);
    issue(500, 5, int'(m[9:5]), int'(m[4:0]), 5);
    start = 1'b0;
    wait_ready();
    m = model(10'd100, 5'd0);
    issue(100, 0, int'(m[9:5]), int'(m[4:0]), 5);
    start = 1'b0;
    wait_ready();
`endif

    // start held high: back-to-back restarts every 6 cycles
    Dividend = 10'd31;
    Divider = 5'd2;
    start = 1'b1;
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.q = 5'd15;
      e.r = 5'd1;
      e.acc = c + 1 + 6 * i;
      e.lat = 5;
      sb.push_back(e);
    end
    while (cyc < c + 14) begin
      @(negedge clk);
      if (cyc == c + 6) check("pulse_high", int'(ready), 1);
      if (cyc == c + 7) check("pulse_low", int'(ready), 0);
    end
    start = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
